// File: rtl/seq_bit_source.sv
// seq_bit_source: input stage for the board-level sequence detector.
// Synchronizes and debounces a push-button and a slide switch, then emits a
// serial bit stream on bit_out with a one-cycle bit_valid strobe.
//   manual mode : one debounced switch bit per button press
//   auto mode   : replays sw_pat MSB-first, one bit every TICK_DIV cycles
// Build option: define SEQ_SRC_LOOP_EN to make auto mode reload sw_pat after
// each pass and run until the next button press stops it.
// Requires PAT_W >= 2, TICK_DIV >= 1, DEBOUNCE_CYCLES >= 1.
module seq_bit_source #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 3,
  parameter int PAT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_raw,
  input  logic             sw_bit_raw,
  input  logic [PAT_W-1:0] sw_pat,
  input  logic             auto_mode,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic [7:0]       bit_cnt
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1: the accepting
  // cycle is the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int TK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);
  localparam int EC_W = $clog2(PAT_W + 1);
`ifdef SEQ_SRC_LOOP_EN
  localparam logic [EC_W-1:0] EC_LAST = EC_W'(PAT_W - 1);
`else
  localparam logic [EC_W-1:0] EC_FULL = EC_W'(PAT_W);
`endif

  logic             btn_s1, btn_s2;
  logic             sw_s1, sw_s2;
  logic [PAT_W-1:0] pat_s1, pat_s2;
  logic             btn_db, sw_db;
  logic [DB_W-1:0]  btn_cnt, sw_cnt;
  logic             press;

  // Two-flop synchronizers for all asynchronous switch/button inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1  <= 1'b0;
      sw_s2  <= 1'b0;
      pat_s1 <= '0;
      pat_s2 <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      sw_s1  <= sw_bit_raw;
      sw_s2  <= sw_s1;
      pat_s1 <= sw_pat;
      pat_s2 <= pat_s1;
    end
  end

  // Button debounce; press pulses in the same cycle the debounced level rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_db  <= 1'b0;
      btn_cnt <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_s2 == btn_db) begin
        btn_cnt <= '0;
      end else if (btn_cnt == DB_LAST) begin
        btn_db  <= btn_s2;
        btn_cnt <= '0;
        press   <= btn_s2;
      end else begin
        btn_cnt <= btn_cnt + DB_W'(1);
      end
    end
  end

  // Switch-bit debounce, same rule as the button.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_db  <= 1'b0;
      sw_cnt <= '0;
    end else begin
      if (sw_s2 == sw_db) begin
        sw_cnt <= '0;
      end else if (sw_cnt == DB_LAST) begin
        sw_db  <= sw_s2;
        sw_cnt <= '0;
      end else begin
        sw_cnt <= sw_cnt + DB_W'(1);
      end
    end
  end

  // state | meaning
  // IDLE  | waiting for a press; manual presses emit one bit directly
  // LOAD  | capture synced sw_pat; first pattern bit strobes on exit
  // SHIFT | emit remaining bits every TICK_DIV cycles, busy held high
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t           state;
  logic [PAT_W-1:0] shift_reg;
  logic [TK_W-1:0]  tick;
  logic [EC_W-1:0]  emitted;

  // Sequencer with registered outputs. The first pattern bit is driven on the
  // LOAD->SHIFT edge so its strobe lands in the first SHIFT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      tick      <= '0;
      emitted   <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      bit_cnt   <= 8'd0;
    end else begin
      bit_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            if (auto_mode) begin
              state <= LOAD;
              busy  <= 1'b1;
            end else begin
              bit_out   <= sw_db;
              bit_valid <= 1'b1;
              bit_cnt   <= bit_cnt + 8'd1;
            end
          end
        end
        LOAD: begin
`ifdef SEQ_SRC_LOOP_EN
          if (press) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
`else
          begin
`endif
            bit_out   <= pat_s2[PAT_W-1];
            bit_valid <= 1'b1;
            bit_cnt   <= bit_cnt + 8'd1;
            shift_reg <= pat_s2 << 1;
            tick      <= '0;
            emitted   <= EC_W'(1);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
`ifdef SEQ_SRC_LOOP_EN
          if (press) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tick == TK_LAST) begin
            tick      <= '0;
            bit_out   <= shift_reg[PAT_W-1];
            bit_valid <= 1'b1;
            bit_cnt   <= bit_cnt + 8'd1;
            // Last bit of the pass: pick up the current switches seamlessly.
            if (emitted == EC_LAST) begin
              shift_reg <= pat_s2;
              emitted   <= '0;
            end else begin
              shift_reg <= shift_reg << 1;
              emitted   <= emitted + EC_W'(1);
            end
          end else begin
            tick <= tick + TK_W'(1);
          end
`else
          if (emitted == EC_FULL) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tick == TK_LAST) begin
            tick      <= '0;
            bit_out   <= shift_reg[PAT_W-1];
            bit_valid <= 1'b1;
            bit_cnt   <= bit_cnt + 8'd1;
            shift_reg <= shift_reg << 1;
            emitted   <= emitted + EC_W'(1);
          end else begin
            tick <= tick + TK_W'(1);
          end
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_source.sv
// Testbench for seq_bit_source: directed scenarios followed by random
// stimulus, every cycle compared against a schedule-based reference model.
module tb_seq_bit_source;
  localparam int D  = 4;
  localparam int TD = 3;
  localparam int PW = 8;
  localparam int N  = 3000;
  localparam int M  = N + 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic       sw_bit_raw = 1'b0;
  logic [7:0] sw_pat = 8'h00;
  logic       auto_mode = 1'b0;
  logic       bit_out, bit_valid, busy;
  logic [7:0] bit_cnt;

  always #5 clk = ~clk;

  seq_bit_source #(.DEBOUNCE_CYCLES(D), .TICK_DIV(TD), .PAT_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_bit_raw(sw_bit_raw),
    .sw_pat(sw_pat), .auto_mode(auto_mode), .bit_out(bit_out),
    .bit_valid(bit_valid), .busy(busy), .bit_cnt(bit_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Input values seen at each rising edge.
  bit       r_btn[N], r_sw[N], r_auto[N], r_rst[N];
  bit [7:0] r_pat[N];
  // Model history and expected-output schedule, indexed by cycle.
  bit       press_a[N], db_sw_a[N];
  bit       ev[M], ebit[M], eb[M];
  bit       m_db_btn = 1'b0, m_db_sw = 1'b0, m_bit = 1'b0;
  int       m_cnt = 0;
  bit       loop_on = 1'b0;
  int       reload_edge = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // Synchronizer output in cycle c: raw value two edges back, zero near reset.
  function automatic bit synced_btn(input int c);
    if (c < 1) return 1'b0;
    if (r_rst[c] || r_rst[c-1]) return 1'b0;
    return r_btn[c-1];
  endfunction

  function automatic bit synced_sw(input int c);
    if (c < 1) return 1'b0;
    if (r_rst[c] || r_rst[c-1]) return 1'b0;
    return r_sw[c-1];
  endfunction

  task automatic clear_from(input int k);
    for (int c = k; c < M; c++) begin
      ev[c] = 1'b0;
      eb[c] = 1'b0;
    end
    loop_on = 1'b0;
  endtask

  task automatic sched_bits(input int first, input bit [7:0] pat);
    for (int i = 0; i < PW; i++) begin
      ev[first + TD*i]   = 1'b1;
      ebit[first + TD*i] = pat[PW-1-i];
    end
  endtask

  // Replay accepted at edge k: LOAD in cycle k, first bit in cycle k+1.
  task automatic start_replay(input int k);
    sched_bits(k + 1, r_pat[k-1]);
`ifdef SEQ_SRC_LOOP_EN
    for (int c = k; c < M; c++) eb[c] = 1'b1;
    loop_on = 1'b1;
    reload_edge = k + 1 + TD*(PW-1);
`else
    for (int c = k; c <= k + 1 + TD*(PW-1); c++) eb[c] = 1'b1;
`endif
  endtask

  task automatic model_edge(input int k);
    bit run;
    if (r_rst[k]) begin
      m_db_btn = 1'b0; m_db_sw = 1'b0; m_bit = 1'b0; m_cnt = 0;
      press_a[k] = 1'b0; db_sw_a[k] = 1'b0;
      clear_from(k);
      return;
    end
    // A level is accepted once the last D synced samples all disagree with it.
    run = 1'b1;
    for (int i = 1; i <= D; i++)
      if (k - i < 0 || synced_btn(k - i) == m_db_btn) run = 1'b0;
    press_a[k] = run && !m_db_btn;
    if (run) m_db_btn = !m_db_btn;
    run = 1'b1;
    for (int i = 1; i <= D; i++)
      if (k - i < 0 || synced_sw(k - i) == m_db_sw) run = 1'b0;
    if (run) m_db_sw = !m_db_sw;
    db_sw_a[k] = m_db_sw;
`ifdef SEQ_SRC_LOOP_EN
    if (loop_on && k == reload_edge) begin
      sched_bits(k + TD, r_pat[k-2]);
      reload_edge = k + TD*PW;
    end
`endif
    if (k >= 1 && press_a[k-1]) begin
      if (!eb[k-1]) begin
        if (r_auto[k]) start_replay(k);
        else begin
          ev[k]   = 1'b1;
          ebit[k] = db_sw_a[k-1];
        end
      end
`ifdef SEQ_SRC_LOOP_EN
      else clear_from(k);
`endif
    end
    if (ev[k]) begin
      m_bit = ebit[k];
      m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  task automatic step();
    if (cyc >= N - 1) begin
      $display("FAIL cycle_budget cycle=%0d got=overrun expected=<%0d", cyc, N);
      $fatal(1, "cycle budget exceeded");
    end
    r_btn[cyc] = btn_raw; r_sw[cyc] = sw_bit_raw; r_auto[cyc] = auto_mode;
    r_pat[cyc] = sw_pat;  r_rst[cyc] = !rst_n;
    @(posedge clk);
    #1;
    model_edge(cyc);
    check_val("bit_valid", 32'(bit_valid), 32'(ev[cyc]));
    check_val("bit_out",   32'(bit_out),   32'(m_bit));
    check_val("busy",      32'(busy),      32'(eb[cyc]));
    check_val("bit_cnt",   32'(bit_cnt),   32'(m_cnt));
    cyc++;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  initial begin
    // Reset with inputs toggling.
    rst_n = 1'b0;
    repeat (3) begin
      btn_raw = 1'($urandom); sw_bit_raw = 1'($urandom);
      sw_pat = 8'($urandom);  auto_mode = 1'($urandom);
      step();
    end
    btn_raw = 1'b0; auto_mode = 1'b0; rst_n = 1'b1;
    hold(6);
    // Manual press with switch high.
    sw_bit_raw = 1'b1; hold(8);
    btn_raw = 1'b1; hold(10);
    btn_raw = 1'b0; hold(12);
    // Bouncing press, then a short glitch.
    for (int i = 0; i < 6; i++) begin
      btn_raw = ~btn_raw; hold(2);
    end
    btn_raw = 1'b1; hold(12);
    btn_raw = 1'b0; hold(12);
    btn_raw = 1'b1; hold(3);
    btn_raw = 1'b0; hold(12);
    // Auto replay with a second press mid-pass.
    sw_pat = 8'b1011_0010; auto_mode = 1'b1; hold(4);
    btn_raw = 1'b1; hold(8);
    btn_raw = 1'b0; hold(6);
    btn_raw = 1'b1; hold(8);
    btn_raw = 1'b0; hold(30);
    // Reset after three bits of a replay.
    sw_pat = 8'($urandom);
    btn_raw = 1'b1; hold(15);
    btn_raw = 1'b0; rst_n = 1'b0; hold(2);
    rst_n = 1'b1; hold(30);
    // Pattern A5; second press well into the replay (stops it in loop builds).
    sw_pat = 8'hA5; auto_mode = 1'b1;
    btn_raw = 1'b1; hold(10);
    btn_raw = 1'b0; hold(30);
    btn_raw = 1'b1; hold(10);
    btn_raw = 1'b0; hold(40);
    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(5) == 0)   btn_raw    = ~btn_raw;
      if ($urandom_range(7) == 0)   sw_bit_raw = ~sw_bit_raw;
      if ($urandom_range(9) == 0)   sw_pat     = 8'($urandom);
      if ($urandom_range(39) == 0)  auto_mode  = ~auto_mode;
      rst_n = ($urandom_range(399) != 0);
      step();
    end
    rst_n = 1'b1; btn_raw = 1'b0;
    hold(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
